// File: rtl/irq_pending_ctrl_if.sv
// Valid/ack handshake carrying the selected interrupt id
// from the pending controller to the exception stage.
interface irq_pending_ctrl_if #(
    parameter int LOGWIDTH = 4
);
    logic                irq_valid;
    logic [LOGWIDTH-1:0] irq_id;
    logic                irq_ack;

    modport master (
        output irq_valid,
        output irq_id,
        input  irq_ack
    );

    modport slave (
        input  irq_valid,
        input  irq_id,
        output irq_ack
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: sync + edge detect, pending/mask registers,
// highest-index priority select, valid/ack presentation.
module irq_pending_ctrl #(
    parameter int LOGWIDTH = 4,
    localparam int N = 2 ** LOGWIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         irq_in,
    input  logic                 mask_we,
    input  logic [N-1:0]         mask_wdata,
    output logic [N-1:0]         mask_q,
    output logic [N-1:0]         pend_q,
    output logic                 irq_none,
    irq_pending_ctrl_if.master   bus
);
    typedef enum logic {
        IDLE,
        PRESENT
    } state_e;

    state_e              state_q, state_d;
    logic [LOGWIDTH-1:0] id_q, id_d;
    logic [N-1:0]        sync1_q, sync2_q, sync3_q;
    logic [N-1:0]        pend_d, mask_d;
    logic [N-1:0]        rise, eff, clr;
    logic [LOGWIDTH-1:0] sel;

    assign rise = sync2_q & ~sync3_q;
    assign eff  = pend_q & mask_q;

    assign irq_none      = (eff == '0);
    assign bus.irq_valid = (state_q == PRESENT);
    assign bus.irq_id    = id_q;

    // Ascending scan: the last hit is the highest set index.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (eff[i]) sel = LOGWIDTH'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                if (eff != '0) begin
                    id_d    = sel;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.irq_ack) begin
                    clr[id_q] = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh rising edge beats the ack clear on the same bit.
    assign pend_d = (pend_q & ~clr) | rise;
    assign mask_d = mask_we ? mask_wdata : mask_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            id_q    <= '0;
            state_q <= IDLE;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
            state_q <= state_d;
        end
    end
endmodule
